// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default constants for the memory arbiter.
// Contents: FSM state encoding, grant id, default parameter values.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {GNT_INST, GNT_DATA} gnt_t;
    localparam int AW_DEF              = 32;
    localparam int DW_DEF              = 32;
    localparam int TIMEOUT_DEF         = 16;
    localparam int MAX_DATA_STREAK_DEF = 4;
endpackage

// File: rtl/mem_arb_ibuf.sv
// mem_arb_ibuf: one-entry fetch buffer (valid, addr, data) for mem_arb.
// Ports: fill_i/fill_addr_i/fill_data_i load the entry; inv_i clears it;
// st_i/st_addr_i clear it on a store to the same word; look_addr_i is
// compared against the entry, giving hit_o and the buffered word data_o.
module mem_arb_ibuf #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [DW-1:0] fill_data_i,
    input  logic          inv_i,
    input  logic          st_i,
    input  logic [AW-1:0] st_addr_i,
    input  logic [AW-1:0] look_addr_i,
    output logic          hit_o,
    output logic [DW-1:0] data_o
);
    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr_i;
            data_q  <= fill_data_i;
        end else if (inv_i || (st_i && st_addr_i[AW-1:2] == addr_q[AW-1:2])) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && look_addr_i == addr_q;
    assign data_o = data_q;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbitrates one single-port memory between instruction fetch and load/store.
// Ports: inst_* fetch port, data_* load/store port, mem_* memory side,
// err_o pulses with the ready of a timed-out access, stall_o is the core stall.
// Option: define MEM_ARB_IBUF_EN to add a one-entry fetch buffer.
import mem_arb_pkg::*;

module mem_arb #(
    parameter int AW              = AW_DEF,
    parameter int DW              = DW_DEF,
    parameter int TIMEOUT         = TIMEOUT_DEF,
    parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req_i,
    input  logic [AW-1:0] inst_addr_i,
    output logic [DW-1:0] inst_data_o,
    output logic          inst_ready_o,
    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_wdata_i,
    output logic [DW-1:0] data_rdata_o,
    output logic          data_ready_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i,
    output logic          err_o,
    output logic          stall_o
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    state_t        state_q, state_d;
    gnt_t          gnt_q, gnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] inst_data_q, inst_data_d;
    logic [DW-1:0] data_rdata_q, data_rdata_d;
    logic          err_q, err_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [SW-1:0] streak_q, streak_d;

    logic          any_req, pick_inst, timeout, buf_hit;
    logic [DW-1:0] buf_data;

    assign any_req   = inst_req_i || data_req_i;
    // Data wins unless instruction fetch has been starved for the full streak.
    assign pick_inst = inst_req_i && (!data_req_i || streak_q == SW'(MAX_DATA_STREAK));
    assign timeout   = wait_cnt_q == WW'(TIMEOUT - 1);

`ifdef MEM_ARB_IBUF_EN
    mem_arb_ibuf #(.AW(AW), .DW(DW)) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .fill_i      (state_q == BUSY && mem_ready_i && gnt_q == GNT_INST),
        .fill_addr_i (mem_addr_q),
        .fill_data_i (mem_rdata_i),
        .inv_i       (state_q == BUSY && !mem_ready_i && timeout),
        .st_i        (state_q == IDLE && any_req && !pick_inst && data_we_i),
        .st_addr_i   (data_addr_i),
        .look_addr_i (inst_addr_i),
        .hit_o       (buf_hit),
        .data_o      (buf_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_INST;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
            err_q        <= 1'b0;
            wait_cnt_q   <= '0;
            streak_q     <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
            err_q        <= err_d;
            wait_cnt_q   <= wait_cnt_d;
            streak_q     <= streak_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;
        err_d        = err_q;
        wait_cnt_d   = state_q == BUSY ? wait_cnt_q + 1'b1 : '0;
        streak_d     = inst_req_i ? streak_q : '0;
        case (state_q)
            IDLE: if (any_req) begin
                err_d = 1'b0;
                if (pick_inst) begin
                    gnt_d    = GNT_INST;
                    streak_d = '0;
                    if (buf_hit) begin
                        inst_data_d = buf_data;
                        state_d     = RESP;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = inst_addr_i;
                        state_d    = BUSY;
                    end
                end else begin
                    gnt_d       = GNT_DATA;
                    streak_d    = inst_req_i ? streak_q + 1'b1 : '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we_i;
                    mem_addr_d  = data_addr_i;
                    mem_wdata_d = data_wdata_i;
                    state_d     = BUSY;
                end
            end
            BUSY: if (mem_ready_i || timeout) begin
                mem_req_d = 1'b0;
                err_d     = !mem_ready_i;
                state_d   = RESP;
                if (gnt_q == GNT_INST)
                    inst_data_d = mem_ready_i ? mem_rdata_i : '0;
                else if (!mem_we_q)
                    data_rdata_d = mem_ready_i ? mem_rdata_i : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_ready_o = state_q == RESP && gnt_q == GNT_INST;
        data_ready_o = state_q == RESP && gnt_q == GNT_DATA;
        err_o        = state_q == RESP && err_q;
        stall_o      = (inst_req_i && !inst_ready_o) || (data_req_i && !data_ready_o);
        mem_req_o    = mem_req_q;
        mem_we_o     = mem_we_q;
        mem_addr_o   = mem_addr_q;
        mem_wdata_o  = mem_wdata_q;
        inst_data_o  = inst_data_q;
        data_rdata_o = data_rdata_q;
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb.
module tb_mem_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_data_o;
    logic        inst_ready_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        err_o;
    logic        stall_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mem_arb dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req_i   (inst_req_i),
        .inst_addr_i  (inst_addr_i),
        .inst_data_o  (inst_data_o),
        .inst_ready_o (inst_ready_o),
        .data_req_i   (data_req_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_ready_o (data_ready_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i),
        .err_o        (err_o),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Wait (bounded) for the memory request, answer it next-cycle style, and
    // return the address that was presented; leaves the bench in the RESP cycle.
    task automatic serve(input logic [31:0] rd, output logic [31:0] addr);
        int n = 0;
        while (!mem_req_o && n < 40) begin
            tick();
            n++;
        end
        check("mem_req_seen", {63'd0, mem_req_o}, 64'd1);
        addr        = mem_addr_o;
        mem_ready_i = 1'b1;
        mem_rdata_i = rd;
        tick();
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
    endtask

    initial begin
        logic [31:0] a;
        int n;
        tick();
        tick();
        check("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        check("rst_readys", {62'd0, inst_ready_o, data_ready_o}, 64'd0);
        check("rst_err_stall", {62'd0, err_o, stall_o}, 64'd0);
        check("rst_addr", {32'd0, mem_addr_o}, 64'd0);

        // single load, memory ready two cycles after mem_req_o
        rst = 1'b0;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h40;
        #1 check("t1_stall", {63'd0, stall_o}, 64'd1);
        tick();
        check("t1_req", {31'd0, mem_req_o, mem_addr_o}, {31'd0, 1'b1, 32'h40});
        check("t1_we", {63'd0, mem_we_o}, 64'd0);
        tick();
        check("t1_busy", {62'd0, mem_req_o, data_ready_o}, 64'd2);
        tick();
        mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        check("t1_busy2", {62'd0, mem_req_o, data_ready_o}, 64'd2);
        tick();
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        check("t1_resp", {29'd0, data_ready_o, mem_req_o, stall_o, data_rdata_o}, {29'd0, 3'b100, 32'hDEADBEEF});
        data_req_i = 1'b0;
        tick();
        check("t1_after", {62'd0, data_ready_o, err_o}, 64'd0);

        // simultaneous requests: data first, then inst
        inst_req_i = 1'b1; inst_addr_i = 32'h200;
        data_req_i = 1'b1; data_addr_i = 32'h80;
        tick();
        check("t2_data_first", {31'd0, stall_o, mem_addr_o}, {31'd0, 1'b1, 32'h80});
        mem_ready_i = 1'b1; mem_rdata_i = 32'h11111111;
        tick();
        mem_ready_i = 1'b0;
        check("t2_data_rdy", {30'd0, data_ready_o, inst_ready_o, data_rdata_o}, {30'd0, 2'b10, 32'h11111111});
        check("t2_stall_inst", {63'd0, stall_o}, 64'd1);
        data_req_i = 1'b0;
        tick();
        check("t2_idle", {62'd0, mem_req_o, stall_o}, 64'd1);
        tick();
        check("t2_inst_addr", {31'd0, mem_req_o, mem_addr_o}, {31'd0, 1'b1, 32'h200});
        mem_ready_i = 1'b1; mem_rdata_i = 32'h22222222;
        tick();
        mem_ready_i = 1'b0;
        check("t2_inst_rdy", {30'd0, inst_ready_o, stall_o, inst_data_o}, {30'd0, 2'b10, 32'h22222222});
        inst_req_i = 1'b0;
        tick();

        // data streak: 5th grant goes to inst
        data_req_i = 1'b1; data_addr_i = 32'h300;
        inst_req_i = 1'b1; inst_addr_i = 32'h400;
        for (int g = 0; g < 6; g++) begin
            serve(32'h5000_0000 + g, a);
            check("streak_addr", {32'd0, a}, g == 4 ? 64'h400 : 64'h300);
            check("streak_rdy", {62'd0, inst_ready_o, data_ready_o}, g == 4 ? 64'd2 : 64'd1);
            if (g == 4) inst_req_i = 1'b0;
        end
        check("streak_idata", {32'd0, inst_data_o}, 64'h5000_0004);
        data_req_i = 1'b0;
        tick();

        // timeout on a fetch
        inst_req_i = 1'b1; inst_addr_i = 32'h500;
        tick();
        n = 0;
        while (mem_req_o && n < 40) begin
            n++;
            tick();
        end
        check("to_busy_cycles", 64'(n), 64'd16);
        check("to_resp", {30'd0, inst_ready_o, err_o, inst_data_o}, {30'd0, 2'b11, 32'h0});
        inst_req_i = 1'b0;
        tick();
        check("to_after", {62'd0, inst_ready_o, err_o}, 64'd0);

        // reset during BUSY
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h600;
        tick();
        check("rb_busy", {63'd0, mem_req_o}, 64'd1);
        rst = 1'b1;
        tick();
        check("rb_cleared", {30'd0, mem_req_o, data_ready_o, data_rdata_o}, 64'd0);
        check("rb_addr", {31'd0, err_o, mem_addr_o}, 64'd0);
        rst = 1'b0;
        tick();
        check("rb_no_rdy", {63'd0, data_ready_o}, 64'd0);
        serve(32'hCAFEF00D, a);
        check("rb_addr2", {32'd0, a}, 64'h600);
        check("rb_resp", {31'd0, data_ready_o, data_rdata_o}, {31'd0, 1'b1, 32'hCAFEF00D});
        data_req_i = 1'b0;
        tick();

        // store keeps data_rdata_o
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h700; data_wdata_i = 32'h12345678;
        tick();
        check("st_req", {31'd0, mem_we_o, mem_wdata_o}, {31'd0, 1'b1, 32'h12345678});
        serve(32'hFFFFFFFF, a);
        check("st_resp", {31'd0, data_ready_o, data_rdata_o}, {31'd0, 1'b1, 32'hCAFEF00D});
        data_req_i = 1'b0; data_we_i = 1'b0;
        tick();

        // repeated fetch of 0x100, then store invalidation
        inst_req_i = 1'b1; inst_addr_i = 32'h100;
        serve(32'hAAAA0001, a);
        check("f1_resp", {31'd0, inst_ready_o, inst_data_o}, {31'd0, 1'b1, 32'hAAAA0001});
        inst_req_i = 1'b0;
        tick();
        inst_req_i = 1'b1;
        tick();
`ifdef MEM_ARB_IBUF_EN
        check("f2_hit", {30'd0, inst_ready_o, mem_req_o, inst_data_o}, {30'd0, 2'b10, 32'hAAAA0001});
`else
        check("f2_miss", {62'd0, inst_ready_o, mem_req_o}, 64'd1);
        serve(32'hBBBB0002, a);
        check("f2_resp", {31'd0, inst_ready_o, inst_data_o}, {31'd0, 1'b1, 32'hBBBB0002});
`endif
        inst_req_i = 1'b0;
        tick();
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h100; data_wdata_i = 32'h0;
        serve(32'h0, a);
        check("f_st_rdy", {63'd0, data_ready_o}, 64'd1);
        data_req_i = 1'b0; data_we_i = 1'b0;
        tick();
        inst_req_i = 1'b1;
        tick();
        check("f3_mem", {62'd0, inst_ready_o, mem_req_o}, 64'd1);
        serve(32'hCCCC0003, a);
        check("f3_resp", {31'd0, inst_ready_o, inst_data_o}, {31'd0, 1'b1, 32'hCCCC0003});
        inst_req_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates one unified single-port memory between the core's instruction-fetch port and its load/store port.
- Sits between the core's inst_*/data_* ports and the memory.
- Sequences every access with a request/ready handshake and supports variable memory latency.
- Guards against a stalled memory with a timeout, and against instruction starvation with a streak limit.
- Drives the core-wide stall.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles one memory access waits for mem_ready_i before abort
- MAX_DATA_STREAK, 4, max consecutive data grants while an instruction request is pending

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- inst_req_i  in  1  fetch request, held until inst_ready_o
- inst_addr_i  in  AW  fetch address, stable while inst_req_i
- inst_data_o  out  DW  fetched word, valid with inst_ready_o
- inst_ready_o  out  1  one-cycle completion pulse
- data_req_i  in  1  load/store request, held until data_ready_o
- data_we_i  in  1  1 = store
- data_addr_i  in  AW  load/store address
- data_wdata_i  in  DW  store data
- data_rdata_o  out  DW  load data, valid with data_ready_o
- data_ready_o  out  1  one-cycle completion pulse
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data, valid with mem_ready_i
- mem_ready_i  in  1  memory completion
- err_o  out  1  one-cycle pulse with the ready pulse of an access aborted by timeout
- stall_o  out  1  any request pending and its ready not asserted this cycle

Behaviour:
- Reset: all outputs are 0; FSM is IDLE; counters and streak are 0.
- Reset mid-access behaves the same: state is discarded, mem_req_o drops the next cycle, and no ready pulse is issued.
- FSM states are IDLE, BUSY, RESP. A grant register (INST/DATA) is captured on leaving IDLE.
- IDLE:
  - If any request is present, grant one, latch its address/we/wdata into the mem_* registers, set mem_req_o=1, and go to BUSY.
  - Priority is data over inst.
  - Exception: if streak==MAX_DATA_STREAK and inst_req_i=1, grant inst.
  - Streak increments on each data grant made while inst_req_i=1. It clears on any inst grant or when inst_req_i=0.
- BUSY: mem_* outputs are held stable; the wait counter increments every cycle.
  - On mem_ready_i=1: capture mem_rdata_i into the granted port's data output, clear mem_req_o, and go to RESP.
  - When the wait counter reaches TIMEOUT-1 without mem_ready_i: clear mem_req_o, drive the port data to 0, set the error flag, and go to RESP.
- RESP:
  - Pulse the granted port's ready_o for exactly one cycle; err_o is set if the access was aborted. Then go to IDLE.
  - No grant is made in RESP, so a requester dropping or changing its request the cycle after ready is never double-served.
- Latency:
  - Request seen at cycle 0 in IDLE gives mem_req_o at cycle 1.
  - mem_ready_i at cycle k (k≥1) gives ready_o at cycle k+1.
  - Minimum 3 cycles per access; the next grant comes at the earliest in the cycle after ready.
- Ports with no grant keep ready_o=0; their data outputs hold their last value.
- stall_o = (inst_req_i & ~inst_ready_o) | (data_req_i & ~data_ready_o), combinational.
- Simultaneous inst and data requests in IDLE follow the priority rule above; the loser keeps waiting and stall_o stays high.
- Store responses return data_rdata_o unchanged.

Optional Feature:
- Macro: MEM_ARB_IBUF_EN.
- Defined: adds a one-entry fetch buffer (valid, addr, data), filled on every non-aborted inst access.
  - An inst request in IDLE whose address equals a valid buffer address, with no data grant taking priority that cycle, is a hit.
  - A hit goes directly to RESP with inst_data_o = buffered word: ready at cycle 1, no memory access.
  - The buffer is invalidated by a data-port store to the same word address at its grant, by a timeout, and by rst.
- Undefined: no buffer; every fetch goes to memory.

Decomposition:
- Package mem_arb_pkg:
  - FSM state encoding (IDLE/BUSY/RESP)
  - grant id (GNT_INST/GNT_DATA)
  - default parameter constants
- Sub-module mem_arb_ibuf holds the fetch buffer. It is instantiated only under MEM_ARB_IBUF_EN.

Test Plan:
- Single load, data_addr_i=0x40, memory ready 2 cycles after mem_req_o with 0xDEADBEEF → data_ready_o pulses 1 cycle later, data_rdata_o=0xDEADBEEF, mem_req_o low in RESP.
- inst and data requests both raised in IDLE → data granted first (mem_addr_o=data addr); inst served next; stall_o high until each ready.
- data_req_i held continuously with inst pending, MAX_DATA_STREAK=4 → the 5th grant goes to inst; then data resumes.
- mem_ready_i never asserted, TIMEOUT=16 → mem_req_o drops after 16 BUSY cycles; inst_ready_o and err_o pulse together; inst_data_o=0.
- rst asserted during BUSY → next cycle all outputs 0, no ready pulse, fresh request served normally.
- MEM_ARB_IBUF_EN defined: fetch 0x100 twice → second fetch is ready 1 cycle after request with no mem_req_o. After a store to 0x100, the next fetch of 0x100 goes to memory.
